// File: rtl/led_stage_ctrl.sv
// led_stage_ctrl
// ---------------------------------------------------------------------------
// Stage sequencer for the LED bar game. A single lit LED walks from led[0]
// toward led[LED_W-1] at a level-dependent step rate. A button press is judged
// against the TARGET position. A hit advances the level, or wins at the last
// level. A miss or a timeout (stepping past the top LED) loses.
//
// Optional feature: define LED_STAGE_LIVES_EN to add a lives counter. A miss
// then restarts the current level until the lives run out.
//
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   start      : start/restart pulse (debounced upstream)
//   btn        : player press pulse, one cycle (debounced upstream)
//   led        : LED bar drive
//   level      : current level, 0-based
//   busy       : high while loading or running a level
//   pass_pulse : one-cycle pulse for each level cleared
//   fail_pulse : one-cycle pulse on a miss or a timeout
//   win        : high while the win pattern is shown
//   lives      : remaining lives (LED_STAGE_LIVES_EN builds only)
// ---------------------------------------------------------------------------
module led_stage_ctrl #(
    parameter int TICK_CYCLES = 50000000,
    parameter int LED_W       = 8,
    parameter int TARGET      = 7,
    parameter int NUM_LEVELS  = 4,
    parameter int LIVES       = 3,
    localparam int LVL_W      = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             btn,
    output logic [LED_W-1:0] led,
    output logic [LVL_W-1:0] level,
    output logic             busy,
    output logic             pass_pulse,
    output logic             fail_pulse,
`ifdef LED_STAGE_LIVES_EN
    output logic [1:0]       lives,
`endif
    output logic             win
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_LEVELS - 1);
    localparam logic [LED_W-1:0] ALL_ONES  = {LED_W{1'b1}};
    localparam logic [LED_W-1:0] LOW_HALF  = ALL_ONES >> (LED_W - LED_W / 2);
    localparam logic [LED_W-1:0] HIGH_HALF = LOW_HALF << (LED_W - LED_W / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WIN,
        S_LOSE
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [LED_W-1:0] led_reg, led_next;
    logic [LVL_W-1:0] level_reg, level_next;
    logic             pass_reg, pass_next;
    logic             fail_reg, fail_next;
`ifdef LED_STAGE_LIVES_EN
    logic [1:0]       lives_reg, lives_next;
`endif

    // The lose pattern blinks at the level-0 rate whatever level was reached.
    logic [31:0] period_raw;
    logic [31:0] period;
    logic        step;

    always_comb begin
        period_raw = (state_reg == S_LOSE) ? 32'(TICK_CYCLES)
                                           : (32'(TICK_CYCLES) >> level_reg);
        period     = (period_raw == 32'd0) ? 32'd1 : period_raw;
        step       = (32'(cnt_reg) >= period - 32'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            led_reg   <= '0;
            level_reg <= '0;
            pass_reg  <= 1'b0;
            fail_reg  <= 1'b0;
`ifdef LED_STAGE_LIVES_EN
            lives_reg <= 2'(LIVES);
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            led_reg   <= led_next;
            level_reg <= level_next;
            pass_reg  <= pass_next;
            fail_reg  <= fail_next;
`ifdef LED_STAGE_LIVES_EN
            lives_reg <= lives_next;
`endif
        end
    end

    always_comb begin
        logic missed;
        state_next = state_reg;
        cnt_next   = step ? '0 : cnt_reg + 1'b1;
        led_next   = led_reg;
        level_next = level_reg;
        pass_next  = 1'b0;
        fail_next  = 1'b0;
        missed     = 1'b0;
`ifdef LED_STAGE_LIVES_EN
        lives_next = lives_reg;
`endif
        case (state_reg)
            S_LOAD: begin
                led_next   = LED_W'(1);
                state_next = S_RUN;
            end
            S_RUN: begin
                // A press outranks a coincident step: it is judged against the
                // current position and the shift is dropped.
                if (btn) begin
                    if (led_reg[TARGET]) begin
                        pass_next = 1'b1;
                        if (level_reg == LVL_MAX) begin
                            led_next   = ALL_ONES;
                            state_next = S_WIN;
                        end else begin
                            level_next = level_reg + 1'b1;
                            state_next = S_LOAD;
                        end
                    end else begin
                        missed = 1'b1;
                    end
                end else if (step) begin
                    if (led_reg[LED_W-1]) begin
                        missed = 1'b1;
                    end else begin
                        led_next = led_reg << 1;
                    end
                end
            end
            S_IDLE, S_WIN, S_LOSE: begin
                if (state_reg == S_LOSE && step) begin
                    led_next = (led_reg == LOW_HALF) ? HIGH_HALF : LOW_HALF;
                end
                if (start) begin
                    level_next = '0;
`ifdef LED_STAGE_LIVES_EN
                    lives_next = 2'(LIVES);
`endif
                    state_next = S_LOAD;
                end
            end
            default: begin
                led_next   = '0;
                state_next = S_IDLE;
            end
        endcase

        if (missed) begin
            fail_next = 1'b1;
`ifdef LED_STAGE_LIVES_EN
            if (lives_reg > 2'd1) begin
                lives_next = lives_reg - 2'd1;
                state_next = S_LOAD;
            end else begin
                lives_next = 2'd0;
                led_next   = LOW_HALF;
                state_next = S_LOSE;
            end
`else
            led_next   = LOW_HALF;
            state_next = S_LOSE;
`endif
        end

        // Every level attempt starts with a fresh step period.
        if (state_next == S_LOAD) begin
            cnt_next = '0;
        end
    end

    assign led        = led_reg;
    assign level      = level_reg;
    assign busy       = (state_reg == S_LOAD) || (state_reg == S_RUN);
    assign win        = (state_reg == S_WIN);
    assign pass_pulse = pass_reg;
    assign fail_pulse = fail_reg;
`ifdef LED_STAGE_LIVES_EN
    assign lives      = lives_reg;
`endif

endmodule
